// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing source
// to the downstream pixel generators.
interface vga_timing_gen_if;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output hpos, vpos, hsync, vsync, display_on,
        output line_start, frame_start, frame_count
    );

    modport slave (
        input hpos, vpos, hsync, vsync, display_on,
        input line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised VGA raster timing source.
// Optional VGA_TIMING_DELAY_EN delays hsync/vsync/display_on by PIPE_DELAY.
module vga_timing_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int PIPE_DELAY  = 2
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vid
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
    localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    localparam logic SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    logic [9:0] hpos_q;
    logic [9:0] vpos_q;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       v_wrap;
    logic [7:0] frame_q;

    logic       hs_d;
    logic       vs_d;
    logic       de_d;
    logic       ls_d;
    logic       fs_d;

    logic       hs_q;
    logic       vs_q;
    logic       de_q;
    logic       ls_q;
    logic       fs_q;

    // Next raster position: exact-compare wraps on both axes.
    always_comb begin
        h_wrap = (hpos_q == H_LAST);
        v_wrap = (vpos_q == V_LAST);
        h_next = h_wrap ? 10'd0 : hpos_q + 10'd1;
        v_next = vpos_q;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vpos_q + 10'd1;
        end
    end

    // Flags decoded from the next position so they line up with it.
    always_comb begin
        hs_d = SYNC_OFF;
        vs_d = SYNC_OFF;
        if (h_next >= HS_FIRST && h_next <= HS_LAST) begin
            hs_d = SYNC_ON;
        end
        if (v_next >= VS_FIRST && v_next <= VS_LAST) begin
            vs_d = SYNC_ON;
        end
        de_d = (h_next < H_ACT) && (v_next < V_ACT);
        ls_d = (h_next == 10'd0);
        fs_d = (h_next == 10'd0) && (v_next == 10'd0);
    end

    // Raster counters and completed-frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q  <= 10'd0;
            vpos_q  <= 10'd0;
            frame_q <= 8'd0;
        end else begin
            hpos_q <= h_next;
            vpos_q <= v_next;
            if (h_wrap && v_wrap) begin
                frame_q <= frame_q + 8'd1;
            end
        end
    end

    // Registered, zero-latency timing flags; reset state is blanked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q <= SYNC_OFF;
            vs_q <= SYNC_OFF;
            de_q <= 1'b0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

`ifdef VGA_TIMING_DELAY_EN
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;
    logic [PIPE_DELAY-1:0] de_pipe;

    // Shift the video flags to match a registered pixel pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_pipe <= {PIPE_DELAY{SYNC_OFF}};
            vs_pipe <= {PIPE_DELAY{SYNC_OFF}};
            de_pipe <= '0;
        end else begin
            hs_pipe[0] <= hs_q;
            vs_pipe[0] <= vs_q;
            de_pipe[0] <= de_q;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
                de_pipe[i] <= de_pipe[i-1];
            end
        end
    end

    assign vid.hsync      = hs_pipe[PIPE_DELAY-1];
    assign vid.vsync      = vs_pipe[PIPE_DELAY-1];
    assign vid.display_on = de_pipe[PIPE_DELAY-1];
`else
    assign vid.hsync      = hs_q;
    assign vid.vsync      = vs_q;
    assign vid.display_on = de_q;
`endif

    assign vid.hpos        = hpos_q;
    assign vid.vpos        = vpos_q;
    assign vid.line_start  = ls_q;
    assign vid.frame_start = fs_q;
    assign vid.frame_count = frame_q;

endmodule
